cp0_int_ctrl: RTL and testbench

Coprocessor-0 and interrupt controller for the five-stage MIPS pipeline. It samples hardware interrupt lines against SR, decides when an interrupt is taken, and drives the `intclr` flush consumed by the pipeline registers. It also captures EPC, steers the PC to the handler and back on `eret`, and services `mtc0`/`mfc0` issued from the MEM stage.

---
 rtl/cp0_int_ctrl.sv | 129 ++++++++++++
 tb/tb_cp0_int_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/cp0_int_ctrl.sv
// Coprocessor-0 register file and interrupt controller for the MIPS pipeline.
// Takes hardware interrupts, flushes the pipe, and steers PC to handler and back.
module cp0_int_ctrl #(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
  parameter logic [31:0] PRID         = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instrM,
  input  logic [31:0] pcM,
  input  logic [31:0] pcE,
  input  logic [31:0] wdataM,
  input  logic [5:0]  hw_int,
  output logic [31:0] rdata,
  output logic        intclr,
  output logic        redirect,
  output logic [31:0] pc_redirect,
  output logic        exl
);

  localparam logic [1:0] RUN     = 2'd0;
  localparam logic [1:0] ENTER   = 2'd1;
  localparam logic [1:0] HANDLER = 2'd2;
  localparam logic [1:0] RETURN  = 2'd3;

  localparam logic [4:0] IDX_SR    = 5'd12;
  localparam logic [4:0] IDX_CAUSE = 5'd13;
  localparam logic [4:0] IDX_EPC   = 5'd14;
  localparam logic [4:0] IDX_PRID  = 5'd15;

  logic [1:0]  state;
  logic [5:0]  srIm;
  logic        srExl;
  logic        srIe;
  logic [5:0]  causeIp;
  logic [31:0] epc;

  logic        isCop0;
  logic        isMfc0;
  logic        isMtc0;
  logic        isEret;
  logic [4:0]  regIdx;
  logic        irqOk;

  assign isCop0 = instrM[31:26] == 6'b010000;
  assign isMfc0 = isCop0 && instrM[25:21] == 5'b00000;
  assign isMtc0 = isCop0 && instrM[25:21] == 5'b00100;
  assign isEret = instrM == 32'h4200_0018;
  assign regIdx = instrM[15:11];

  // mtc0/eret in MEM must commit, so a pending interrupt waits a cycle
  assign irqOk = (|(hw_int & srIm)) && srIe && !srExl
              && state == RUN && !isMtc0 && !isEret;

  assign intclr = irqOk;
  assign exl    = srExl;

  // ExcCode is only ever loaded with 0, so Cause[6:2] reads as constant 0
  always_comb begin
    rdata = 32'h0;
    unique case (regIdx)
      IDX_SR:    rdata = {16'h0, srIm, 8'h0, srExl, srIe};
      IDX_CAUSE: rdata = {16'h0, causeIp, 10'h0};
      IDX_EPC:   rdata = epc;
      IDX_PRID:  rdata = PRID;
      default:   rdata = 32'h0;
    endcase
  end

  always_comb begin
    redirect    = 1'b0;
    pc_redirect = 32'h0;
    unique case (1'b1)
      state == ENTER: begin
        redirect    = 1'b1;
        pc_redirect = HANDLER_ADDR;
      end
      state == RETURN: begin
        redirect    = 1'b1;
        pc_redirect = epc;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= RUN;
      srIm    <= 6'h0;
      srExl   <= 1'b0;
      srIe    <= 1'b0;
      causeIp <= 6'h0;
      epc     <= 32'h0;
    end else begin
      causeIp <= hw_int;
      if (isMtc0) begin
        if (regIdx == IDX_SR) begin
          srIm  <= wdataM[15:10];
          srExl <= wdataM[1];
          srIe  <= wdataM[0];
        end
        if (regIdx == IDX_EPC)
          epc <= wdataM;
      end
      unique case (state)
        RUN: begin
          if (irqOk) begin
            state <= ENTER;
            epc   <= (instrM != 32'h0) ? pcM : pcE;
            srExl <= 1'b1;
          end
        end
        ENTER: state <= HANDLER;
        HANDLER: begin
          if (isEret) begin
            state <= RETURN;
            srExl <= 1'b0;
          end
        end
        RETURN: state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

  logic unusedMfc0;
  assign unusedMfc0 = isMfc0;

endmodule

// File: tb/tb_cp0_int_ctrl.sv
// Directed table-driven bench for cp0_int_ctrl: interrupt entry, return,
// deferral behind mtc0/eret, EPC capture and reset out of the handler.
module tb_cp0_int_ctrl;

  localparam logic [31:0] HADDR = 32'h0000_4180;
  localparam logic [31:0] PRIDV = 32'h0000_0000;
  localparam logic [31:0] ERET  = 32'h4200_0018;
  localparam logic [31:0] ADDI  = 32'h0109_5020;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instrM;
  logic [31:0] pcM;
  logic [31:0] pcE;
  logic [31:0] wdataM;
  logic [5:0]  hw_int;
  logic [31:0] rdata;
  logic        intclr;
  logic        redirect;
  logic [31:0] pc_redirect;
  logic        exl;

  int compared = 0;
  int mismatched = 0;

  cp0_int_ctrl #(.HANDLER_ADDR(HADDR), .PRID(PRIDV)) dut (
    .clk(clk),
    .reset(reset),
    .instrM(instrM),
    .pcM(pcM),
    .pcE(pcE),
    .wdataM(wdataM),
    .hw_int(hw_int),
    .rdata(rdata),
    .intclr(intclr),
    .redirect(redirect),
    .pc_redirect(pc_redirect),
    .exl(exl)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pcm;
    logic [31:0] pce;
    logic [31:0] wdata;
    logic [5:0]  hw;
    logic        chkR;
    logic [31:0] expR;
    logic        expClr;
    logic        expRed;
    logic [31:0] expPc;
    logic        expExl;
  } vec_t;

  function automatic logic [31:0] mfc0(input logic [4:0] rd);
    return {6'b010000, 5'd0, 5'd8, rd, 11'd0};
  endfunction

  function automatic logic [31:0] mtc0(input logic [4:0] rd);
    return {6'b010000, 5'd4, 5'd8, rd, 11'd0};
  endfunction

  function automatic vec_t mk(
    input logic [31:0] i, input logic [31:0] pm, input logic [31:0] pe,
    input logic [31:0] wd, input logic [5:0] h, input logic cr,
    input logic [31:0] er, input logic ec, input logic erd,
    input logic [31:0] ep, input logic ex);
    vec_t v;
    v.instr = i; v.pcm = pm; v.pce = pe; v.wdata = wd; v.hw = h;
    v.chkR = cr; v.expR = er; v.expClr = ec; v.expRed = erd;
    v.expPc = ep; v.expExl = ex;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] i, input logic [31:0] pm,
                       input logic [31:0] pe, input logic [31:0] wd,
                       input logic [5:0] h);
    instrM = i; pcM = pm; pcE = pe; wdataM = wd; hw_int = h;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[26];

  initial begin
    vecs[0]  = mk(mfc0(12), 0, 0, 0, 6'h0, 1, 32'h0, 0, 0, 32'h0, 0);
    vecs[1]  = mk(mfc0(13), 0, 0, 0, 6'h0, 1, 32'h0, 0, 0, 32'h0, 0);
    vecs[2]  = mk(mfc0(14), 0, 0, 0, 6'h0, 1, 32'h0, 0, 0, 32'h0, 0);
    vecs[3]  = mk(mfc0(15), 0, 0, 0, 6'h0, 1, PRIDV, 0, 0, 32'h0, 0);
    vecs[4]  = mk(32'h0, 0, 0, 0, 6'h0, 1, 32'h0, 0, 0, 32'h0, 0);
    vecs[5]  = mk(mtc0(12), 0, 0, 32'h401, 6'h0, 0, 0, 0, 0, 32'h0, 0);
    vecs[6]  = mk(mfc0(12), 0, 0, 0, 6'h0, 1, 32'h401, 0, 0, 32'h0, 0);
    vecs[7]  = mk(ADDI, 32'h3008, 32'h300C, 0, 6'h1, 0, 0, 1, 0, 32'h0, 0);
    vecs[8]  = mk(32'h0, 0, 0, 0, 6'h0, 1, 32'h0, 0, 1, HADDR, 1);
    vecs[9]  = mk(mfc0(14), 0, 0, 0, 6'h0, 1, 32'h3008, 0, 0, 32'h0, 1);
    vecs[10] = mk(mfc0(13), 0, 0, 0, 6'h1, 1, 32'h0, 0, 0, 32'h0, 1);
    vecs[11] = mk(mfc0(13), 0, 0, 0, 6'h1, 1, 32'h400, 0, 0, 32'h0, 1);
    vecs[12] = mk(mtc0(14), 0, 0, 32'h3100, 6'h0, 0, 0, 0, 0, 32'h0, 1);
    vecs[13] = mk(mfc0(14), 0, 0, 0, 6'h0, 1, 32'h3100, 0, 0, 32'h0, 1);
    vecs[14] = mk(ERET, 0, 0, 0, 6'h0, 0, 0, 0, 0, 32'h0, 1);
    vecs[15] = mk(32'h0, 0, 0, 0, 6'h1, 1, 32'h0, 0, 1, 32'h3100, 0);
    vecs[16] = mk(mtc0(12), 0, 0, 32'h401, 6'h1, 0, 0, 0, 0, 32'h0, 0);
    vecs[17] = mk(32'h0, 32'h3FF0, 32'h300C, 0, 6'h1, 1, 32'h0, 1, 0, 32'h0, 0);
    vecs[18] = mk(mfc0(14), 0, 0, 0, 6'h0, 1, 32'h300C, 0, 1, HADDR, 1);
    vecs[19] = mk(ERET, 0, 0, 0, 6'h0, 0, 0, 0, 0, 32'h0, 1);
    vecs[20] = mk(32'h0, 0, 0, 0, 6'h0, 1, 32'h0, 0, 1, 32'h300C, 0);
    vecs[21] = mk(ERET, 0, 0, 0, 6'h1, 0, 0, 0, 0, 32'h0, 0);
    vecs[22] = mk(ADDI, 32'h3010, 32'h3014, 0, 6'h1, 0, 0, 1, 0, 32'h0, 0);
    vecs[23] = mk(mfc0(14), 0, 0, 0, 6'h0, 1, 32'h3010, 0, 1, HADDR, 1);
    vecs[24] = mk(mtc0(12), 0, 0, 32'h401, 6'h0, 0, 0, 0, 0, 32'h0, 1);
    vecs[25] = mk(32'h0, 0, 0, 0, 6'h1, 1, 32'h0, 0, 0, 32'h0, 0);

    reset = 1'b1;
    drive(32'h0, 0, 0, 0, 6'h0);
    nextCycle();
    nextCycle();
    reset = 1'b0;

    for (int i = 0; i < 26; i++) begin
      drive(vecs[i].instr, vecs[i].pcm, vecs[i].pce,
            vecs[i].wdata, vecs[i].hw);
      #1;
      if (vecs[i].chkR)
        check($sformatf("v%0d rdata", i), rdata, vecs[i].expR);
      check($sformatf("v%0d intclr", i), {31'h0, intclr},
            {31'h0, vecs[i].expClr});
      check($sformatf("v%0d redirect", i), {31'h0, redirect},
            {31'h0, vecs[i].expRed});
      check($sformatf("v%0d pc_redirect", i), pc_redirect, vecs[i].expPc);
      check($sformatf("v%0d exl", i), {31'h0, exl},
            {31'h0, vecs[i].expExl});
      nextCycle();
    end

    // still in HANDLER with EXL cleared by mtc0; reset must return to RUN
    reset = 1'b1;
    drive(mtc0(14), 0, 0, 32'hDEAD_BEEF, 6'h1);
    nextCycle();
    reset = 1'b0;
    drive(mfc0(12), 0, 0, 0, 6'h1);
    #1;
    check("rst sr", rdata, 32'h0);
    check("rst intclr", {31'h0, intclr}, 32'h0);
    check("rst redirect", {31'h0, redirect}, 32'h0);
    check("rst pc_redirect", pc_redirect, 32'h0);
    check("rst exl", {31'h0, exl}, 32'h0);
    drive(mfc0(14), 0, 0, 0, 6'h1);
    #1;
    check("rst epc", rdata, 32'h0);
    nextCycle();
    drive(mtc0(12), 0, 0, 32'h401, 6'h0);
    nextCycle();
    drive(ADDI, 32'h3020, 32'h3024, 0, 6'h1);
    #1;
    check("post-rst intclr", {31'h0, intclr}, 32'h1);
    nextCycle();
    drive(mfc0(14), 0, 0, 0, 6'h0);
    #1;
    check("post-rst redirect", {31'h0, redirect}, 32'h1);
    check("post-rst pc_redirect", pc_redirect, HADDR);
    check("post-rst epc", rdata, 32'h3020);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
